// File: rtl/seven_segment_scan_driver.sv
// Multiplexed 4-digit seven-segment driver: prescaled scan, blanking gap, frame double-buffer, leading-zero blanking.
// Latency: outputs registered; load reaches the pins at the next frame boundary (same-cycle bypass on the boundary).
// Backpressure: none; load is always accepted, and the last load before a boundary wins.
// Ports: clock/reset (sync, active-high); load/digitsIn/dpIn fill the pending buffer;
//        enable forces dark; leadingZeroSuppress blanks leading zeros; anode/cathode/dp are active-low pins;
//        digitSelect is the live scan index; frameDone pulses on the last cycle of the digit-3 slot.
module seven_segment_scan_driver #(
    parameter int CLOCK_DIVIDE = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] digitsIn,
    input  logic [3:0]  dpIn,
    input  logic        enable,
    input  logic        leadingZeroSuppress,
    output logic [3:0]  anode,
    output logic [6:0]  cathode,
    output logic        dp,
    output logic [1:0]  digitSelect,
    output logic        frameDone
);

    localparam int CW = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [15:0]   pend_dig_q, pend_dig_d, disp_dig_q, disp_dig_d;
    logic [3:0]    pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    logic [3:0]    anode_q, anode_d;
    logic [6:0]    cathode_q, cathode_d;
    logic          dp_q, dp_d;
    logic          frame_done_q, frame_done_d;

    logic          slot_end;
    logic          frame_end;
    logic          active;
    logic [3:0]    nib;
    logic [3:0]    lead_zero;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_end  = (cnt_q == CW'(CLOCK_DIVIDE - 1));
        frame_end = slot_end && (sel_q == 2'd3);

        cnt_d = slot_end ? '0 : cnt_q + CW'(1);
        sel_d = slot_end ? sel_q + 2'd1 : sel_q;

        pend_dig_d = load ? digitsIn : pend_dig_q;
        pend_dp_d  = load ? dpIn     : pend_dp_q;
        // Taking the post-load pending value gives the same-cycle bypass on the boundary.
        disp_dig_d = frame_end ? pend_dig_d : disp_dig_q;
        disp_dp_d  = frame_end ? pend_dp_d  : disp_dp_q;

        // Output registers are loaded from next-state values so the pins line up with cnt_q/sel_q.
        nib = disp_dig_d[sel_d*4 +: 4];
        lead_zero[3] = (disp_dig_d[15:12] == 4'h0);
        lead_zero[2] = lead_zero[3] && (disp_dig_d[11:8] == 4'h0);
        lead_zero[1] = lead_zero[2] && (disp_dig_d[7:4] == 4'h0);
        lead_zero[0] = 1'b0;

        active = enable && (cnt_d >= CW'(BLANK_CYCLES));

        anode_d   = 4'hF;
        cathode_d = 7'h7F;
        dp_d      = 1'b1;
        if (active) begin
            anode_d = ~(4'b0001 << sel_d);
            dp_d    = ~disp_dp_d[sel_d];
            if (!(leadingZeroSuppress && lead_zero[sel_d])) begin
                cathode_d = hex_to_seg(nib);
            end
        end

        frame_done_d = (cnt_d == CW'(CLOCK_DIVIDE - 1)) && (sel_d == 2'd3);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q        <= '0;
            sel_q        <= 2'd0;
            pend_dig_q   <= 16'h0;
            pend_dp_q    <= 4'h0;
            disp_dig_q   <= 16'h0;
            disp_dp_q    <= 4'h0;
            anode_q      <= 4'hF;
            cathode_q    <= 7'h7F;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            pend_dig_q   <= pend_dig_d;
            pend_dp_q    <= pend_dp_d;
            disp_dig_q   <= disp_dig_d;
            disp_dp_q    <= disp_dp_d;
            anode_q      <= anode_d;
            cathode_q    <= cathode_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign anode       = anode_q;
    assign cathode     = cathode_q;
    assign dp          = dp_q;
    assign digitSelect = sel_q;
    assign frameDone   = frame_done_q;

endmodule
